// File: rtl/amber_ic_pkg.sv
// Shared constants for the vectored Amber interrupt controller: register offsets,
// the unmapped-read pattern and the vector register layout.
package amber_ic_pkg;

  localparam logic [7:0] AMBER_IC_RAWSTAT_OFF     = 8'h00;
  localparam logic [7:0] AMBER_IC_IRQ_STATUS_OFF  = 8'h04;
  localparam logic [7:0] AMBER_IC_IRQ_ENSET_OFF   = 8'h08;
  localparam logic [7:0] AMBER_IC_IRQ_ENCLR_OFF   = 8'h0C;
  localparam logic [7:0] AMBER_IC_FIRQ_STATUS_OFF = 8'h10;
  localparam logic [7:0] AMBER_IC_FIRQ_ENSET_OFF  = 8'h14;
  localparam logic [7:0] AMBER_IC_FIRQ_ENCLR_OFF  = 8'h18;
  localparam logic [7:0] AMBER_IC_SOFTSET_OFF     = 8'h1C;
  localparam logic [7:0] AMBER_IC_SOFTCLR_OFF     = 8'h20;
  localparam logic [7:0] AMBER_IC_EDGE_MODE_OFF   = 8'h24;
  localparam logic [7:0] AMBER_IC_PENDING_OFF     = 8'h28;
  localparam logic [7:0] AMBER_IC_IRQ_VECTOR_OFF  = 8'h2C;
  localparam logic [7:0] AMBER_IC_FIRQ_VECTOR_OFF = 8'h30;

  localparam logic [31:0] AMBER_IC_DEFAULT_RDATA = 32'h2233_4455;
  localparam int          AMBER_IC_VEC_VALID_BIT = 31;

  function automatic logic [31:0] make_vector(input logic valid, input logic [4:0] id);
    logic [31:0] v;
    v = '0;
    v[AMBER_IC_VEC_VALID_BIT] = valid;
    v[4:0] = id;
    return v;
  endfunction

endpackage

// File: rtl/amber_ic_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set and the
// index of the lowest set bit.
module amber_ic_prio_enc #(
  parameter int N_SRC = 16
) (
  input  logic [N_SRC-1:0] stat,
  output logic             valid,
  output logic [4:0]       id
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    id    = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (stat[i]) begin
        valid = 1'b1;
        id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_vec.sv
// Vectored Amber interrupt controller: Wishbone slave masking N_SRC sources onto o_irq/o_firq.
// Define AMBER_IC_EDGE_EN to build per-source rising-edge mode with a W1C pending latch.
module interrupt_controller_vec
  import amber_ic_pkg::*;
#(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4,
  parameter int N_SRC     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  input  logic [N_SRC-2:0]     i_src,
  output logic                 o_irq,
  output logic                 o_firq
);

  logic [31:0]      wdata32, rdata32, rd_next;
  logic [7:0]       reg_off;
  logic             read_d1, start_read, wb_write;
  logic [N_SRC-1:0] wmask, sync, active, irq_stat, firq_stat;
  logic [N_SRC-1:0] irq_en, firq_en, edge_mode_rd, pending_rd;
  logic [N_SRC-2:0] src_meta, src_sync;
  logic             softint;
  logic             irq_valid, firq_valid;
  logic [4:0]       irq_id, firq_id;
  logic             unused_bits;

  assign reg_off    = {i_wb_adr[7:2], 2'b00};
  assign start_read = i_wb_stb & ~i_wb_we & ~o_wb_ack;
  assign wb_write   = i_wb_stb & i_wb_we & ~read_d1;
  assign o_wb_ack   = wb_write | read_d1;
  assign o_wb_err   = 1'b0;
  assign wmask      = wdata32[N_SRC-1:0];
  assign unused_bits = ^{i_wb_sel, i_wb_cyc, i_wb_adr[31:8], i_wb_adr[1:0], wdata32};

  // A 128-bit bus picks the write lane by address and replicates read data.
  generate
    if (WB_DWIDTH == 128) begin : g_wb128
      assign wdata32  = i_wb_dat[{i_wb_adr[3:2], 5'd0} +: 32];
      assign o_wb_dat = {4{rdata32}};
    end else begin : g_wb32
      assign wdata32  = i_wb_dat[31:0];
      assign o_wb_dat = rdata32;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_meta <= '0;
      src_sync <= '0;
    end else begin
      src_meta <= i_src;
      src_sync <= src_meta;
    end
  end

  assign sync = {src_sync, softint};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_en  <= '0;
      firq_en <= '0;
      softint <= 1'b0;
    end else if (wb_write) begin
      case (reg_off)
        AMBER_IC_IRQ_ENSET_OFF:  irq_en  <= irq_en | wmask;
        AMBER_IC_IRQ_ENCLR_OFF:  irq_en  <= irq_en & ~wmask;
        AMBER_IC_FIRQ_ENSET_OFF: firq_en <= firq_en | wmask;
        AMBER_IC_FIRQ_ENCLR_OFF: firq_en <= firq_en & ~wmask;
        AMBER_IC_SOFTSET_OFF:    if (wdata32[0]) softint <= 1'b1;
        AMBER_IC_SOFTCLR_OFF:    if (wdata32[0]) softint <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef AMBER_IC_EDGE_EN
  logic [N_SRC-1:0] edge_mode, pending, sync_d, pend_set, pend_clr;

  // A fresh edge beats a same-cycle W1C or mode change so no event is lost.
  always_comb begin
    pend_set = sync & ~sync_d & edge_mode;
    pend_clr = '0;
    if (wb_write && reg_off == AMBER_IC_PENDING_OFF)   pend_clr = wmask;
    if (wb_write && reg_off == AMBER_IC_EDGE_MODE_OFF) pend_clr = wmask ^ edge_mode;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      edge_mode <= '0;
      pending   <= '0;
      sync_d    <= '0;
    end else begin
      sync_d  <= sync;
      pending <= (pending & ~pend_clr) | pend_set;
      if (wb_write && reg_off == AMBER_IC_EDGE_MODE_OFF) edge_mode <= wmask;
    end
  end

  assign active       = (edge_mode & pending) | (~edge_mode & sync);
  assign edge_mode_rd = edge_mode;
  assign pending_rd   = pending;
`else
  assign active       = sync;
  assign edge_mode_rd = '0;
  assign pending_rd   = '0;
`endif

  assign irq_stat  = active & irq_en;
  assign firq_stat = active & firq_en;

  amber_ic_prio_enc #(.N_SRC(N_SRC)) u_irq_enc (
    .stat  (irq_stat),
    .valid (irq_valid),
    .id    (irq_id)
  );

  amber_ic_prio_enc #(.N_SRC(N_SRC)) u_firq_enc (
    .stat  (firq_stat),
    .valid (firq_valid),
    .id    (firq_id)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq  <= 1'b0;
      o_firq <= 1'b0;
    end else begin
      o_irq  <= |irq_stat;
      o_firq <= |firq_stat;
    end
  end

  always_comb begin
    case (reg_off)
      AMBER_IC_RAWSTAT_OFF:     rd_next = 32'(sync);
      AMBER_IC_IRQ_STATUS_OFF:  rd_next = 32'(irq_stat);
      AMBER_IC_IRQ_ENSET_OFF:   rd_next = 32'(irq_en);
      AMBER_IC_IRQ_ENCLR_OFF:   rd_next = 32'(irq_en);
      AMBER_IC_FIRQ_STATUS_OFF: rd_next = 32'(firq_stat);
      AMBER_IC_FIRQ_ENSET_OFF:  rd_next = 32'(firq_en);
      AMBER_IC_FIRQ_ENCLR_OFF:  rd_next = 32'(firq_en);
      AMBER_IC_SOFTSET_OFF:     rd_next = {31'd0, softint};
      AMBER_IC_SOFTCLR_OFF:     rd_next = {31'd0, softint};
      AMBER_IC_EDGE_MODE_OFF:   rd_next = 32'(edge_mode_rd);
      AMBER_IC_PENDING_OFF:     rd_next = 32'(pending_rd);
      AMBER_IC_IRQ_VECTOR_OFF:  rd_next = make_vector(irq_valid, irq_id);
      AMBER_IC_FIRQ_VECTOR_OFF: rd_next = make_vector(firq_valid, firq_id);
      default:                  rd_next = AMBER_IC_DEFAULT_RDATA;
    endcase
  end

  // Read data is captured on the request cycle and acknowledged one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_d1 <= 1'b0;
      rdata32 <= '0;
    end else begin
      read_d1 <= start_read;
      if (start_read) rdata32 <= rd_next;
    end
  end

endmodule

// File: tb/tb_interrupt_controller_vec.sv
// Bench for interrupt_controller_vec: Wishbone reads are scoreboarded by a negedge
// monitor; interrupt line timing is checked directly against hand-derived edges.
module tb_interrupt_controller_vec;

  localparam logic [7:0] RAWSTAT     = 8'h00;
  localparam logic [7:0] IRQ_STATUS  = 8'h04;
  localparam logic [7:0] IRQ_ENSET   = 8'h08;
  localparam logic [7:0] IRQ_ENCLR   = 8'h0C;
  localparam logic [7:0] FIRQ_STATUS = 8'h10;
  localparam logic [7:0] FIRQ_ENSET  = 8'h14;
  localparam logic [7:0] FIRQ_ENCLR  = 8'h18;
  localparam logic [7:0] SOFTSET     = 8'h1C;
  localparam logic [7:0] SOFTCLR     = 8'h20;
  localparam logic [7:0] EDGE_MODE   = 8'h24;
  localparam logic [7:0] PENDING     = 8'h28;
  localparam logic [7:0] IRQ_VECTOR  = 8'h2C;
  localparam logic [7:0] FIRQ_VECTOR = 8'h30;

  typedef struct packed {
    logic [7:0]  adr;
    logic [31:0] dat;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_wdat, wb_rdat;
  logic        wb_ack, wb_err;
  logic [14:0] src;
  logic        irq, firq;
  logic        err_seen = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  rd_exp_t exp_q[$];

  always #5 clk = ~clk;

  interrupt_controller_vec #(
    .WB_DWIDTH (32),
    .WB_SWIDTH (4),
    .N_SRC     (16)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .i_wb_dat (wb_wdat),
    .o_wb_dat (wb_rdat),
    .o_wb_ack (wb_ack),
    .o_wb_err (wb_err),
    .i_src    (src),
    .o_irq    (irq),
    .o_firq   (firq)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  task automatic apply_stimulus(input logic [14:0] s);
    src = s;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = {24'd0, a}; wb_wdat = d;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, input logic [31:0] e);
    rd_exp_t x;
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {24'd0, a};
    x.adr = a; x.dat = e;
    exp_q.push_back(x);
    @(posedge clk);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
  endtask

  // Scoreboard monitor: every read acknowledge consumes one queued expectation.
  always @(negedge clk) begin
    rd_exp_t x;
    if (wb_err === 1'b1) err_seen = 1'b1;
    if (wb_ack === 1'b1 && wb_we == 1'b0) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("[TB] FAIL unexpected_read_ack: got ack with data 0x%08h expected no ack", wb_rdat);
      end else begin
        x = exp_q.pop_front();
        check_output($sformatf("read_%02h", x.adr), wb_rdat, x.dat);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wb_adr = '0; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    wb_wdat = '0; src = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_irq", 32'(irq), 32'd0);
    check_output("reset_firq", 32'(firq), 32'd0);
    wb_read(IRQ_ENSET, 32'd0);
    wb_read(SOFTSET, 32'd0);
    wb_read(IRQ_VECTOR, 32'd0);

    $display("[TB] level source");
    wb_write(IRQ_ENSET, 32'h4);
    @(posedge clk); #1 apply_stimulus(15'h0002);
    @(posedge clk);
    @(posedge clk); #1 check_output("level_irq_k1", 32'(irq), 32'd0);
    @(posedge clk); #1 check_output("level_irq_k2", 32'(irq), 32'd1);
    wb_read(IRQ_VECTOR, 32'h8000_0002);
    wb_read(RAWSTAT, 32'h0000_0004);
    @(posedge clk); #1 apply_stimulus(15'h0000);
    @(posedge clk);
    @(posedge clk); #1 check_output("level_drop_k1", 32'(irq), 32'd1);
    @(posedge clk); #1 check_output("level_drop_k2", 32'(irq), 32'd0);
    wb_write(IRQ_ENCLR, 32'h4);

    $display("[TB] priority");
    wb_write(IRQ_ENSET, 32'hFFFF);
    @(posedge clk); #1 apply_stimulus(15'h0844);
    repeat (3) @(posedge clk);
    #1 check_output("prio_irq", 32'(irq), 32'd1);
    wb_read(IRQ_VECTOR, 32'h8000_0003);
    wb_read(IRQ_STATUS, 32'h0000_1088);
    wb_write(IRQ_ENCLR, 32'h8);
    wb_read(IRQ_VECTOR, 32'h8000_0007);
    wb_write(FIRQ_ENSET, 32'h80);
    @(posedge clk); #1 check_output("prio_firq", 32'(firq), 32'd1);
    wb_read(FIRQ_VECTOR, 32'h8000_0007);
    wb_read(FIRQ_STATUS, 32'h0000_0080);
    wb_write(IRQ_ENCLR, 32'hFFFF);
    check_output("enclr_irq_t", 32'(irq), 32'd1);
    @(posedge clk); #1 check_output("enclr_irq_t1", 32'(irq), 32'd0);
    wb_write(FIRQ_ENCLR, 32'hFFFF);
    @(posedge clk); #1 check_output("enclr_firq_t1", 32'(firq), 32'd0);
    apply_stimulus(15'h0000);
    wb_read(IRQ_VECTOR, 32'd0);

    $display("[TB] width and unmapped");
    wb_write(IRQ_ENSET, 32'hFFFF_FFFF);
    wb_read(IRQ_ENSET, 32'h0000_FFFF);
    wb_write(IRQ_ENCLR, 32'hFFFF_FFFF);
    wb_write(8'h44, 32'hFFFF_FFFF);
    wb_read(IRQ_ENSET, 32'd0);
    wb_read(8'h40, 32'h2233_4455);
    wb_read(8'hFC, 32'h2233_4455);

    $display("[TB] software interrupt");
    wb_write(IRQ_ENSET, 32'h1);
    wb_write(SOFTSET, 32'h1);
    check_output("soft_irq_t", 32'(irq), 32'd0);
    @(posedge clk); #1 check_output("soft_irq_t1", 32'(irq), 32'd1);
    wb_read(RAWSTAT, 32'h0000_0001);
    wb_read(IRQ_VECTOR, 32'h8000_0000);
    wb_write(SOFTCLR, 32'h1);
    @(posedge clk); #1 check_output("softclr_irq", 32'(irq), 32'd0);
    wb_read(SOFTSET, 32'd0);
    wb_write(IRQ_ENCLR, 32'h1);

    $display("[TB] bus read then write");
    wb_write(IRQ_ENSET, 32'h10);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {24'd0, IRQ_ENSET};
    @(negedge clk); check_output("bus_ack_c1", 32'(wb_ack), 32'd0);
    @(posedge clk); #1;
    wb_we = 1'b1; wb_adr = {24'd0, IRQ_ENCLR}; wb_wdat = 32'h10;
    @(negedge clk);
    check_output("bus_ack_c2", 32'(wb_ack), 32'd1);
    check_output("bus_data_c2", wb_rdat, 32'h10);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    wb_read(IRQ_ENSET, 32'h10);
    wb_write(IRQ_ENCLR, 32'h10);
    wb_read(IRQ_ENSET, 32'd0);

`ifdef AMBER_IC_EDGE_EN
    $display("[TB] edge source");
    wb_write(EDGE_MODE, 32'h20);
    wb_write(FIRQ_ENSET, 32'h20);
    @(posedge clk); #1 apply_stimulus(15'h0010);
    @(posedge clk); #1 apply_stimulus(15'h0000);
    @(posedge clk);
    @(posedge clk); #1 check_output("edge_firq_k2", 32'(firq), 32'd0);
    @(posedge clk); #1 check_output("edge_firq_k3", 32'(firq), 32'd1);
    repeat (4) @(posedge clk);
    #1 check_output("edge_firq_held", 32'(firq), 32'd1);
    wb_read(PENDING, 32'h20);
    wb_read(EDGE_MODE, 32'h20);
    wb_read(FIRQ_VECTOR, 32'h8000_0005);
    wb_write(PENDING, 32'h20);
    check_output("w1c_firq_t", 32'(firq), 32'd1);
    @(posedge clk); #1 check_output("w1c_firq_t1", 32'(firq), 32'd0);
    wb_read(PENDING, 32'd0);
    wb_write(FIRQ_ENCLR, 32'h20);
`else
    $display("[TB] edge registers absent");
    wb_write(EDGE_MODE, 32'h20);
    wb_write(PENDING, 32'hFFFF);
    wb_read(EDGE_MODE, 32'd0);
    wb_read(PENDING, 32'd0);
`endif

    $display("[TB] reset mid-operation");
    wb_write(IRQ_ENSET, 32'h6);
    wb_write(FIRQ_ENSET, 32'h4);
    wb_write(SOFTSET, 32'h1);
`ifdef AMBER_IC_EDGE_EN
    wb_write(EDGE_MODE, 32'h20);
`endif
    @(posedge clk); #1 apply_stimulus(15'h0012);
    @(posedge clk); #1 apply_stimulus(15'h0002);
    repeat (3) @(posedge clk);
    #1;
    check_output("pre_rst_irq", 32'(irq), 32'd1);
    check_output("pre_rst_firq", 32'(firq), 32'd1);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {24'd0, IRQ_ENSET}; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0; apply_stimulus(15'h0000);
    @(negedge clk);
    check_output("rst_no_ack", 32'(wb_ack), 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    check_output("rst_firq", 32'(firq), 32'd0);
    wb_read(IRQ_ENSET, 32'd0);
    wb_read(FIRQ_ENSET, 32'd0);
    wb_read(SOFTSET, 32'd0);
    wb_read(RAWSTAT, 32'd0);
    wb_read(FIRQ_VECTOR, 32'd0);
    wb_read(EDGE_MODE, 32'd0);
    wb_read(PENDING, 32'd0);

`ifdef AMBER_IC_EDGE_EN
    $display("[TB] edge set vs W1C collision");
    wb_write(EDGE_MODE, 32'h20);
    @(posedge clk); #1 apply_stimulus(15'h0010);
    @(posedge clk); #1;
    wb_write(PENDING, 32'h20);
    apply_stimulus(15'h0000);
    wb_read(PENDING, 32'h20);
    wb_write(EDGE_MODE, 32'h0);
    wb_read(PENDING, 32'd0);
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("[TB] FAIL outstanding_reads: got %0d unacknowledged expected 0", exp_q.size());
    end
    chk_cnt++;
    if (!err_seen) pass_cnt++;
    else $display("[TB] FAIL wb_err: got 1 expected 0");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/interrupt_controller_vec.md
# interrupt_controller_vec

Parametrised, vectored successor to the Amber interrupt controller: a Wishbone slave that masks up to 32 interrupt sources onto the core's `o_irq` / `o_firq` lines. Per source it adds input synchronisation, selectable level or edge mode with a write-1-to-clear pending latch, and a priority-encoded vector register that gives the handler the winning source ID in one read. It sits in the system block between peripheral interrupt outputs and the Amber core, at the same Wishbone slot class as the existing controller.

## Interface
- `WB_DWIDTH`, 32: Wishbone data width, 32 or 128; 128 replicates read data ×4 and selects write lane by `i_wb_adr[3:2]`.
- `WB_SWIDTH`, 4: byte-select width.
- `N_SRC`, 16: number of source bits, 2..32. Bit 0 is the software interrupt; bits `N_SRC-1:1` come from `i_src`.
- `i_clk` input 1: system clock; single clock domain.
- `i_rst` input 1: **reset is synchronous and active-high.**
- `i_wb_adr` input 32: byte address; the register index is `i_wb_adr[7:2]`.
- `i_wb_sel` input WB_SWIDTH: ignored; full-word accesses only.
- `i_wb_we`, `i_wb_cyc`, `i_wb_stb` input 1: Wishbone control.
- `i_wb_dat` input WB_DWIDTH: write data.
- `o_wb_dat` output WB_DWIDTH: read data.
- `o_wb_ack` output 1: cycle acknowledge.
- `o_wb_err` output 1: tied to 0.
- `i_src` input N_SRC-1: asynchronous peripheral interrupts (ascending bits map to source 1 upward).
- `o_irq`, `o_firq` output 1: registered interrupt requests to the core.

## Operation
- Sources pass through a 2-flop synchroniser. `sync[0]` is `softint_reg`, which is never synchronised.
- Mode per bit, set by `EDGE_MODE`: 0 = level, 1 = rising-edge.
- Level mode: `active = sync`.
- Edge mode: `pending` is set when `sync & ~sync_d`, then `active = pending`.
- `irq_stat = active & irq_en` and `firq_stat = active & firq_en`.
- The registered `o_irq = |irq_stat` and `o_firq = |firq_stat`.
- Priority: the lowest set index wins. `IRQ_VECTOR` returns `{valid, 26'd0, id[4:0]}` for `irq_stat`, and `FIRQ_VECTOR` does the same for `firq_stat`. A read with none pending returns 0.
- Register map (offset, access):
  - 0x00 RAWSTAT R: `sync` (bit 0 = softint).
  - 0x04 IRQ_STATUS R.
  - 0x08 IRQ_ENSET R/W-set.
  - 0x0C IRQ_ENCLR W-clear.
  - 0x10 FIRQ_STATUS R.
  - 0x14 FIRQ_ENSET R/W-set.
  - 0x18 FIRQ_ENCLR W-clear.
  - 0x1C SOFTSET R/W (`[0]` sets).
  - 0x20 SOFTCLR W (`[0]` clears).
  - 0x24 EDGE_MODE R/W.
  - 0x28 PENDING R/W1C.
  - 0x2C IRQ_VECTOR R.
  - 0x30 FIRQ_VECTOR R.
- Unmapped reads return 0x22334455. Unmapped writes are ignored.
- Bits at and above `N_SRC` read 0 and are not writable.
- Changing a bit of `EDGE_MODE` clears that bit's `pending`.
- Simultaneous edge-set and W1C of the same `pending` bit: set wins.

## Timing
- Write: `o_wb_ack = i_wb_stb & i_wb_we & ~read_d1`, same cycle. The register updates at that edge.
- Read: `start_read = stb & ~we & ~ack`. Data is registered and ack is asserted on the following cycle, so each read costs exactly 2 cycles.
- A write is held off while a read ack is outstanding.
- Level-mode latency: a source high before edge k gives `o_irq` high after edge k+2. Deassertion follows with the same latency.
- Edge-mode latency: `pending` is set at edge k+2 and `o_irq` at edge k+3. A pulse must be ≥1 clock wide, plus the synchroniser setup margin.
- Interrupt effect of a write: an ENCLR/W1C write at edge t drops `o_irq` after edge t+1.
- Reset: all enables, `EDGE_MODE`, `pending`, `softint`, the synchronisers, `read_d1` and read data are cleared to 0. `o_irq = o_firq = 0` the cycle after reset.
- Reset mid-read: no ack is issued.

## Configuration
- `AMBER_IC_EDGE_EN` defined: edge mode, the `pending` latch, `EDGE_MODE` and `PENDING` are present, as described above.
- `AMBER_IC_EDGE_EN` undefined: all sources are level-only. `EDGE_MODE` and `PENDING` read 0 and ignore writes, and no edge-detect flops are built.

## Structure
- Package `amber_ic_pkg`: register offset constants (`AMBER_IC_*_OFF`), the 0x22334455 default, and the vector `valid` bit position.
- Sub-module `amber_ic_prio_enc`, parameterised by `N_SRC`: combinational lowest-index encoder producing `{valid, id[4:0]}`. It is instantiated twice (IRQ, FIRQ).

## Test plan
- Level source: write IRQ_ENSET = 0x4, then raise `i_src[1]` (source 2) at edge k. Expect `o_irq` = 1 after k+2, IRQ_VECTOR = 0x80000002, and `o_irq` = 0 three edges after the source drops.
- Edge source: write EDGE_MODE = 0x20 and FIRQ_ENSET = 0x20, then apply a 1-cycle pulse on source 5. Expect `o_firq` held at 1 and PENDING = 0x20. Write PENDING = 0x20: `o_firq` falls after t+1.
- Priority: enable 0xFFFF and assert sources 3, 7 and 12 together. Expect IRQ_VECTOR = 0x80000003; after clearing the 3 enable, expect 0x80000007.
- Software interrupt: write SOFTSET = 1 with IRQ_ENSET = 1. Expect `o_irq` after 1 edge, RAWSTAT[0] = 1, and vector 0x80000000. SOFTCLR = 1 clears it.
- Bus: issue back-to-back read then write. Expect the read ack at cycle 2 with the write ack deferred, an unmapped read returning 0x22334455, and `o_wb_err` = 0 throughout.
- Reset mid-operation: with pending and enables set, assert `i_rst` for 1 cycle. Expect all registers to read 0, `o_irq` = `o_firq` = 0, and the edge-set vs W1C same-cycle collision to leave `pending` = 1.
